// File: rtl/decode_execute_unit.sv
// Two-stage decode/execute block: stage 1 decodes the instruction and drives
// register-file read addresses, stage 2 runs the ALU and branch unit.
module decode_execute_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned INSTR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INSTR_W-1:0] instruction,
  input  logic [DATA_W-1:0] curr_pc,
  input  logic [DATA_W-1:0] reg_data_a,
  input  logic [DATA_W-1:0] reg_data_b,
  output logic [3:0]        rs1_addr,
  output logic [3:0]        rs2_addr,
  output logic [DATA_W-1:0] alu_out,
  output logic              carry_out,
  output logic              cmp_out,
  output logic [3:0]        regdst_out,
  output logic [3:0]        opcode_out,
  output logic [DATA_W-1:0] read_data2_out,
  output logic              pc_load_en,
  output logic [DATA_W-1:0] pc_load_val
);

  localparam int unsigned FIELD_W = 4;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_CMP  = 4'h9;
  localparam logic [3:0] OP_MOV  = 4'hA;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;

  logic [FIELD_W-1:0] op_d;
  logic [FIELD_W-1:0] rd_d;
  logic [FIELD_W-1:0] rs1_d;
  logic [FIELD_W-1:0] rs2_d;

  logic [DATA_W-1:0] alu_nxt;
  logic              carry_nxt;
  logic              cmp_nxt;
  logic              br_take;
  logic [DATA_W-1:0] br_target;

  // The Rs2 field doubles as the zero-extended immediate / shift amount.
  assign rs1_addr = rs1_d;
  assign rs2_addr = rs2_d;

  // Stage 1: capture instruction fields.
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_d  <= '0;
      rd_d  <= '0;
      rs1_d <= '0;
      rs2_d <= '0;
    end else begin
      op_d  <= instruction[INSTR_W-1 -: FIELD_W];
      rd_d  <= instruction[INSTR_W-FIELD_W-1 -: FIELD_W];
      rs1_d <= instruction[2*FIELD_W-1 -: FIELD_W];
      rs2_d <= instruction[FIELD_W-1:0];
    end
  end

  // Branch target: current PC plus sign-extended 4-bit offset from the Regdst field.
  assign br_target = curr_pc + {{(DATA_W-FIELD_W){rd_d[FIELD_W-1]}}, rd_d};

  // Execute: ALU result, carry, compare flag and branch decision.
  always_comb begin
    alu_nxt   = '0;
    carry_nxt = 1'b0;
    cmp_nxt   = cmp_out;
    br_take   = 1'b0;
    case (op_d)
      OP_ADD:  {carry_nxt, alu_nxt} = {1'b0, reg_data_a} + {1'b0, reg_data_b};
      OP_SUB: begin
        alu_nxt   = reg_data_a - reg_data_b;
        carry_nxt = (reg_data_a < reg_data_b);
      end
      OP_AND:  alu_nxt = reg_data_a & reg_data_b;
      OP_OR:   alu_nxt = reg_data_a | reg_data_b;
      OP_XOR:  alu_nxt = reg_data_a ^ reg_data_b;
      OP_SHL:  alu_nxt = reg_data_a << rs2_d;
      OP_SHR:  alu_nxt = reg_data_a >> rs2_d;
      OP_ADDI: {carry_nxt, alu_nxt} = {1'b0, reg_data_a} + (DATA_W+1)'(rs2_d);
      OP_CMP:  cmp_nxt = (reg_data_a == reg_data_b);
      OP_MOV:  alu_nxt = reg_data_b;
      OP_BEQ:  br_take = cmp_out;
      OP_JMP:  br_take = 1'b1;
      default: ;
    endcase
  end

  // Stage 2: register execute results; PC-load value holds unless a branch is taken.
  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_out        <= '0;
      carry_out      <= 1'b0;
      cmp_out        <= 1'b0;
      regdst_out     <= '0;
      opcode_out     <= '0;
      read_data2_out <= '0;
      pc_load_en     <= 1'b0;
      pc_load_val    <= '0;
    end else begin
      alu_out        <= alu_nxt;
      carry_out      <= carry_nxt;
      cmp_out        <= cmp_nxt;
      regdst_out     <= rd_d;
      opcode_out     <= op_d;
      read_data2_out <= reg_data_b;
      pc_load_en     <= br_take;
      if (br_take) pc_load_val <= br_target;
    end
  end

endmodule

// File: tb/tb_decode_execute_unit.sv
// Directed testbench for decode_execute_unit.
module tb_decode_execute_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instruction;
  logic [31:0] curr_pc;
  logic [31:0] reg_data_a;
  logic [31:0] reg_data_b;
  logic [3:0]  rs1_addr;
  logic [3:0]  rs2_addr;
  logic [31:0] alu_out;
  logic        carry_out;
  logic        cmp_out;
  logic [3:0]  regdst_out;
  logic [3:0]  opcode_out;
  logic [31:0] read_data2_out;
  logic        pc_load_en;
  logic [31:0] pc_load_val;

  int passed = 0;
  int total  = 0;

  decode_execute_unit #(.DATA_W(32), .INSTR_W(16)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .curr_pc(curr_pc),
    .reg_data_a(reg_data_a), .reg_data_b(reg_data_b),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .alu_out(alu_out),
    .carry_out(carry_out), .cmp_out(cmp_out), .regdst_out(regdst_out),
    .opcode_out(opcode_out), .read_data2_out(read_data2_out),
    .pc_load_en(pc_load_en), .pc_load_val(pc_load_val)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Decode one instruction, then present its operands for the execute edge.
  task automatic run_op(input logic [15:0] ins, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc);
    instruction = ins;
    step();
    instruction = 16'h0000;
    reg_data_a  = a;
    reg_data_b  = b;
    curr_pc     = pc;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    instruction = 16'($urandom);
    reg_data_a = $urandom;
    reg_data_b = $urandom;
    curr_pc = $urandom;
    step();
    step();
    total++; if (rs1_addr !== 4'd0) $display("FAIL reset_rs1 got %0h want 0", rs1_addr); else passed++;
    total++; if (rs2_addr !== 4'd0) $display("FAIL reset_rs2 got %0h want 0", rs2_addr); else passed++;
    total++; if (alu_out !== 32'd0) $display("FAIL reset_alu got %0h want 0", alu_out); else passed++;
    total++; if (carry_out !== 1'b0) $display("FAIL reset_carry got %0b want 0", carry_out); else passed++;
    total++; if (cmp_out !== 1'b0) $display("FAIL reset_cmp got %0b want 0", cmp_out); else passed++;
    total++; if (regdst_out !== 4'd0) $display("FAIL reset_regdst got %0h want 0", regdst_out); else passed++;
    total++; if (opcode_out !== 4'd0) $display("FAIL reset_opcode got %0h want 0", opcode_out); else passed++;
    total++; if (read_data2_out !== 32'd0) $display("FAIL reset_rd2 got %0h want 0", read_data2_out); else passed++;
    total++; if (pc_load_en !== 1'b0) $display("FAIL reset_pcen got %0b want 0", pc_load_en); else passed++;
    total++; if (pc_load_val !== 32'd0) $display("FAIL reset_pcval got %0h want 0", pc_load_val); else passed++;
    rst = 1'b1;
    instruction = 16'h0000;
    reg_data_a = 32'd0;
    reg_data_b = 32'd0;
    curr_pc = 32'd0;
    step();
    step();
    total++; if (alu_out !== 32'd0 || opcode_out !== 4'd0 || pc_load_en !== 1'b0)
      $display("FAIL nop_stream alu=%0h op=%0h pcen=%0b want 0/0/0", alu_out, opcode_out, pc_load_en);
    else passed++;
  endtask

  task automatic test_add();
    instruction = 16'h1423;
    step();
    total++; if (rs1_addr !== 4'd2 || rs2_addr !== 4'd3)
      $display("FAIL add_addr rs1=%0d rs2=%0d want 2/3", rs1_addr, rs2_addr);
    else passed++;
    instruction = 16'h0000;
    reg_data_a = 32'd5;
    reg_data_b = 32'd7;
    step();
    total++; if (alu_out !== 32'd12) $display("FAIL add_alu got %0d want 12", alu_out); else passed++;
    total++; if (carry_out !== 1'b0) $display("FAIL add_carry got %0b want 0", carry_out); else passed++;
    total++; if (regdst_out !== 4'd4) $display("FAIL add_regdst got %0d want 4", regdst_out); else passed++;
    total++; if (opcode_out !== 4'd1) $display("FAIL add_opcode got %0d want 1", opcode_out); else passed++;
    total++; if (read_data2_out !== 32'd7) $display("FAIL add_rd2 got %0d want 7", read_data2_out); else passed++;
  endtask

  task automatic test_carry_borrow();
    run_op(16'h1123, 32'hFFFF_FFFF, 32'd1, 32'd0);
    total++; if (alu_out !== 32'd0 || carry_out !== 1'b1)
      $display("FAIL add_ovf alu=%0h c=%0b want 0/1", alu_out, carry_out);
    else passed++;
    run_op(16'h2123, 32'd3, 32'd5, 32'd0);
    total++; if (alu_out !== 32'hFFFF_FFFE || carry_out !== 1'b1)
      $display("FAIL sub_borrow alu=%0h c=%0b want fffffffe/1", alu_out, carry_out);
    else passed++;
    run_op(16'h2123, 32'd5, 32'd3, 32'd0);
    total++; if (alu_out !== 32'd2 || carry_out !== 1'b0)
      $display("FAIL sub_noborrow alu=%0h c=%0b want 2/0", alu_out, carry_out);
    else passed++;
  endtask

  task automatic test_logic();
    run_op(16'h3123, 32'h0000_F0F0, 32'h0000_FF00, 32'd0);
    total++; if (alu_out !== 32'h0000_F000) $display("FAIL and got %0h want f000", alu_out); else passed++;
    run_op(16'h4123, 32'h0000_F0F0, 32'h0000_FF00, 32'd0);
    total++; if (alu_out !== 32'h0000_FFF0) $display("FAIL or got %0h want fff0", alu_out); else passed++;
    run_op(16'h5123, 32'h0000_F0F0, 32'h0000_FF00, 32'd0);
    total++; if (alu_out !== 32'h0000_0FF0) $display("FAIL xor got %0h want ff0", alu_out); else passed++;
    run_op(16'hA123, 32'h1111_1111, 32'hDEAD_BEEF, 32'd0);
    total++; if (alu_out !== 32'hDEAD_BEEF || carry_out !== 1'b0)
      $display("FAIL mov alu=%0h c=%0b want deadbeef/0", alu_out, carry_out);
    else passed++;
    run_op(16'hE123, 32'd5, 32'd7, 32'd0);
    total++; if (alu_out !== 32'd0 || opcode_out !== 4'hE)
      $display("FAIL reserved alu=%0h op=%0h want 0/e", alu_out, opcode_out);
    else passed++;
  endtask

  task automatic test_shift_imm();
    run_op(16'h6134, 32'd1, 32'd0, 32'd0);
    total++; if (alu_out !== 32'h10) $display("FAIL shl got %0h want 10", alu_out); else passed++;
    run_op(16'h713F, 32'h8000_0000, 32'd0, 32'd0);
    total++; if (alu_out !== 32'h0001_0000) $display("FAIL shr got %0h want 10000", alu_out); else passed++;
    run_op(16'h813F, 32'd1, 32'd0, 32'd0);
    total++; if (alu_out !== 32'd16 || carry_out !== 1'b0)
      $display("FAIL addi alu=%0d c=%0b want 16/0", alu_out, carry_out);
    else passed++;
    run_op(16'h8131, 32'hFFFF_FFFF, 32'd0, 32'd0);
    total++; if (alu_out !== 32'd0 || carry_out !== 1'b1)
      $display("FAIL addi_ovf alu=%0h c=%0b want 0/1", alu_out, carry_out);
    else passed++;
  endtask

  // CMP immediately followed by BEQ; taken when equal, untaken when not.
  task automatic test_cmp_beq(input logic [31:0] b, input logic exp_taken,
                              input logic [31:0] exp_val);
    instruction = 16'h9012;
    step();
    instruction = 16'hBE00;
    reg_data_a = 32'd9;
    reg_data_b = b;
    step();
    total++; if (cmp_out !== exp_taken) $display("FAIL cmp_flag got %0b want %0b", cmp_out, exp_taken); else passed++;
    total++; if (pc_load_en !== 1'b0) $display("FAIL cmp_nopc got %0b want 0", pc_load_en); else passed++;
    instruction = 16'h0000;
    curr_pc = 32'h10;
    step();
    total++; if (pc_load_en !== exp_taken || pc_load_val !== exp_val)
      $display("FAIL beq en=%0b val=%0h want %0b/%0h", pc_load_en, pc_load_val, exp_taken, exp_val);
    else passed++;
    total++; if (alu_out !== 32'd0 || carry_out !== 1'b0)
      $display("FAIL beq_alu alu=%0h c=%0b want 0/0", alu_out, carry_out);
    else passed++;
    step();
    total++; if (pc_load_en !== 1'b0 || pc_load_val !== exp_val)
      $display("FAIL beq_pulse en=%0b val=%0h want 0/%0h", pc_load_en, pc_load_val, exp_val);
    else passed++;
  endtask

  task automatic test_jmp_hold();
    logic cmp_before;
    cmp_before = cmp_out;
    run_op(16'hC300, 32'd0, 32'd1, 32'h20);
    total++; if (pc_load_en !== 1'b1 || pc_load_val !== 32'h23)
      $display("FAIL jmp en=%0b val=%0h want 1/23", pc_load_en, pc_load_val);
    else passed++;
    total++; if (cmp_out !== cmp_before) $display("FAIL jmp_cmp got %0b want %0b", cmp_out, cmp_before); else passed++;
    curr_pc = 32'h40;
    step();
    total++; if (pc_load_en !== 1'b0 || pc_load_val !== 32'h23)
      $display("FAIL nop_hold en=%0b val=%0h want 0/23", pc_load_en, pc_load_val);
    else passed++;
    total++; if (cmp_out !== cmp_before) $display("FAIL nop_cmp got %0b want %0b", cmp_out, cmp_before); else passed++;
  endtask

  task automatic test_back_to_back();
    instruction = 16'h1512;
    step();
    instruction = 16'h2634;
    reg_data_a = 32'd10;
    reg_data_b = 32'd4;
    step();
    total++; if (alu_out !== 32'd14 || regdst_out !== 4'd5 || rs1_addr !== 4'd3)
      $display("FAIL b2b_add alu=%0d rd=%0d rs1=%0d want 14/5/3", alu_out, regdst_out, rs1_addr);
    else passed++;
    instruction = 16'h0000;
    reg_data_a = 32'd10;
    reg_data_b = 32'd3;
    step();
    total++; if (alu_out !== 32'd7 || regdst_out !== 4'd6 || opcode_out !== 4'd2)
      $display("FAIL b2b_sub alu=%0d rd=%0d op=%0d want 7/6/2", alu_out, regdst_out, opcode_out);
    else passed++;
  endtask

  task automatic test_reset_midflight();
    run_op(16'h9012, 32'd1, 32'd1, 32'd0);
    run_op(16'hC500, 32'd0, 32'd0, 32'h100);
    instruction = 16'h1423;
    reg_data_a = 32'd5;
    reg_data_b = 32'd7;
    step();
    rst = 1'b0;
    step();
    total++; if (alu_out !== 32'd0 || cmp_out !== 1'b0 || opcode_out !== 4'd0 || rs1_addr !== 4'd0)
      $display("FAIL mid_reset alu=%0h cmp=%0b op=%0h rs1=%0h want 0", alu_out, cmp_out, opcode_out, rs1_addr);
    else passed++;
    total++; if (pc_load_val !== 32'd0 || read_data2_out !== 32'd0)
      $display("FAIL mid_reset_pc val=%0h rd2=%0h want 0/0", pc_load_val, read_data2_out);
    else passed++;
    rst = 1'b1;
    instruction = 16'h1423;
    step();
    instruction = 16'h0000;
    step();
    total++; if (alu_out !== 32'd12 || opcode_out !== 4'd1)
      $display("FAIL post_reset alu=%0d op=%0d want 12/1", alu_out, opcode_out);
    else passed++;
  endtask

  initial begin
    rst = 1'b0;
    instruction = 16'h0000;
    curr_pc = 32'd0;
    reg_data_a = 32'd0;
    reg_data_b = 32'd0;
    test_reset();
    test_add();
    test_carry_borrow();
    test_logic();
    test_shift_imm();
    test_cmp_beq(32'd9, 1'b1, 32'h0E);
    test_jmp_hold();
    test_cmp_beq(32'd8, 1'b0, 32'h23);
    test_back_to_back();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/decode_execute_unit.md
Name: decode_execute_unit

Overview:
- Merges the instruction decoder, the ALU and the branch unit into one two-stage block.
- Stage 1 decodes a 16-bit instruction and drives register-file read addresses. Stage 2 executes the instruction and produces ALU results for write-back plus a PC-load request for the fetch unit.
- Sits between instruction fetch / register file (upstream) and write-back (downstream).

Parameters:
- DATA_W, 32, datapath and PC width.
- INSTR_W, 16, instruction width (fixed field layout below).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- instruction  in  16  instruction from fetch.
- curr_pc  in  32  current PC from fetch.
- reg_data_a  in  32  register file read data for rs1_addr (combinational read).
- reg_data_b  in  32  register file read data for rs2_addr.
- rs1_addr  out  4  registered Rs1 address.
- rs2_addr  out  4  registered Rs2 address.
- alu_out  out  32  ALU result.
- carry_out  out  1  carry/borrow of last ALU op.
- cmp_out  out  1  compare flag.
- regdst_out  out  4  destination register of executed instruction.
- opcode_out  out  4  opcode of executed instruction.
- read_data2_out  out  32  registered copy of reg_data_b.
- pc_load_en  out  1  one-cycle PC-load request.
- pc_load_val  out  32  branch target.

Behaviour:
- Instruction fields: [15:12] opcode, [11:8] Regdst / branch offset, [7:4] Rs1, [3:0] Rs2 / imm.
- Stage 1 (decode), every rising edge: register opcode, Regdst, Rs1, Rs2 and imm.
- rs1_addr and rs2_addr come from the stage-1 registers. reg_data_a/b therefore belong to the decoded instruction in the same cycle.
- Stage 2 (execute), every rising edge:
  - register alu_out, carry_out, regdst_out, opcode_out and read_data2_out from the decoded instruction;
  - latency from instruction to outputs is 2 edges.
- Opcodes (A=reg_data_a, B=reg_data_b, imm zero-extended):
  - 0 NOP: alu_out=0, carry=0.
  - 1 ADD: {carry,alu_out}=A+B (33-bit).
  - 2 SUB: alu_out=A-B; carry=1 when A<B unsigned (borrow).
  - 3 AND, 4 OR, 5 XOR: bitwise; carry=0.
  - 6 SHL: A<<imm; carry=0.
  - 7 SHR: A>>imm (logical); carry=0.
  - 8 ADDI: {carry,alu_out}=A+imm.
  - 9 CMP: cmp_out<=(A==B); alu_out=0, carry=0.
  - A MOV: alu_out=B; carry=0.
  - B BEQ: branch if cmp_out==1.
  - C JMP: unconditional branch.
  - D-F reserved: treated as NOP, opcode still forwarded.
- cmp_out changes only on CMP and holds its value across all other opcodes.
- Branch handling (BEQ/C JMP):
  - evaluated in stage 2;
  - target = curr_pc sampled at the execute edge + sign-extended 4-bit Regdst offset, modulo 2^32;
  - pc_load_en=1 for exactly one cycle when taken, else 0;
  - pc_load_val updates only when taken, else holds;
  - BEQ/JMP produce alu_out=0, carry=0.
- CMP immediately followed by BEQ uses the new flag, with no stall: the CMP result is registered on the same edge the BEQ is decoded.
- No internal flush on branch; the fetch unit squashes wrong-path instructions.
- Reset (rst==0 at rising edge): all stage registers and every output go to 0, including cmp_out, pc_load_en and pc_load_val.
  - Opcode 0 makes the pipeline a NOP stream.
  - Reset mid-operation discards in-flight instructions; the first valid outputs appear 2 edges after rst returns to 1.
- Writes into the regfile are outside this block; regdst_out and opcode_out are passed through for write-back decisions.

Test Plan:
- Reset: rst=0 for 2 edges with random instruction → every output 0; release, instruction=0x0000 → outputs stay 0.
- ADD: instruction 0x1423; rs1_addr=2, rs2_addr=3 after 1 edge; drive A=5, B=7 → after 2nd edge alu_out=12, carry=0, regdst_out=4, opcode_out=1, read_data2_out=7.
- Carry/borrow: ADD A=0xFFFFFFFF, B=1 → alu_out=0, carry=1. SUB A=3, B=5 → alu_out=0xFFFFFFFE, carry=1.
- Shifts/imm: 0x6134 with A=1 → alu_out=0x10. 0x713F with A=0x80000000 → 0x00010000. 0x813F with A=1 → 16.
- CMP then BEQ: 0x9012 with A=B=9 → cmp_out=1. Next cycle BEQ 0xBE00, curr_pc=0x10 → pc_load_en pulses 1 cycle, pc_load_val=0x0E. Repeat with A≠B → pc_load_en stays 0.
- JMP/hold: 0xC300, curr_pc=0x20 → pc_load_val=0x23 while cmp_out unchanged. Then NOP → pc_load_en=0, pc_load_val holds 0x23.
